fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC and issues word requests to instruction memory over a valid/ready port.
- Buffers returned words with their PC in a small in-order queue and presents {pc, pc+4, instr} to decode with a valid/ready handshake.
- Decode supplies opcode = instr[6:0] and funct3 = instr[14:12] to the main decoder; a branch/JAL/JALR redirect from execute flushes the stage.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode types, constants and opcode map
package fetch_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - imem request/response, redirect and decode handshake bundle
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int XLEN = fetch_pkg::XLEN
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pcplus4;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pcplus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pcplus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           dec_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order queue of fetched {pc, instr} entries with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, credit-limited imem requester and decode-facing queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int       CW   = $clog2(DEPTH + 1);
  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occupancy;
  logic [CW+1:0]   in_use;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  logic [XLEN-1:0] target;
  logic            unused_pc_lsbs;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  // queued entries, requests in flight and stale responses all consume one credit
  assign in_use   = (CW+2)'(occupancy) + (CW+2)'(outstanding) + (CW+2)'(drop_cnt);
  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (state == RUN)
                              && (in_use < (CW+2)'(DEPTH));
  assign bus.imem_req_addr  = pc;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire  = !reset && bus.imem_rsp_valid;
  assign push      = rsp_fire && !bus.redirect_valid && (drop_cnt == '0);
  assign pop       = bus.if_valid && bus.dec_ready;
  assign push_data = '{pc: rsp_pc, instr: bus.imem_rsp_data};
  assign target    = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

  assign bus.if_valid   = !empty && !bus.redirect_valid;
  assign bus.if_pc      = empty ? '0 : head.pc;
  assign bus.if_instr   = empty ? '0 : head.instr;
  assign bus.if_pcplus4 = empty ? '0 : head.pc + XLEN'(4);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .count     (occupancy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state <= RUN;
      if (bus.redirect_valid) begin
        pc          <= target;
        rsp_pc      <= target;
        drop_cnt    <= drop_cnt + outstanding - CW'(bus.imem_rsp_valid);
        outstanding <= '0;
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (push) rsp_pc <= rsp_pc + XLEN'(4);
        outstanding <= outstanding + CW'(req_fire) - CW'(push);
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
      assert (!(rsp_fire && (drop_cnt == '0) && (outstanding == '0)));
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a latency-programmable imem model
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // memory returns 0x1000_0000 + addr, mem_lat cycles after the request handshake
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data  = '0;
  logic        inj_valid = 1'b0;
  logic [31:0] inj_data  = '0;
  int unsigned mem_lat   = 1;
  int unsigned edge_n    = 0;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  logic [31:0] pop_log[$];

  assign bus.imem_rsp_valid = mem_valid | inj_valid;
  assign bus.imem_rsp_data  = inj_valid ? inj_data : mem_data;

  always @(posedge clk) begin
    int unsigned n;
    n = edge_n + 1;
    edge_n <= n;
    mem_valid <= 1'b0;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend_addr.push_back(bus.imem_req_addr);
        pend_due.push_back(n - 1 + mem_lat);
      end
      if (pend_due.size() > 0 && pend_due[0] <= n) begin
        mem_valid <= 1'b1;
        mem_data  <= 32'h1000_0000 + pend_addr[0];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && bus.if_valid && bus.dec_ready) pop_log.push_back(bus.if_pc);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;
    step(); step();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
    chk("rst_if_valid", 32'(bus.if_valid), 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_if_instr", bus.if_instr, 0);
    chk("rst_if_pcplus4", bus.if_pcplus4, 0);
    chk("rst_req_addr", bus.imem_req_addr, 0);

    // steady stream, latency 1
    reset = 1'b0; #1;
    chk("boot_no_req", 32'(bus.imem_req_valid), 0);
    step(); chk("r1_req_valid", 32'(bus.imem_req_valid), 1); chk("r1_addr", bus.imem_req_addr, 32'h0);
    step(); chk("r2_addr", bus.imem_req_addr, 32'h4);
    step();
    chk("r3_req_valid", 32'(bus.imem_req_valid), 0);
    chk("r3_if_valid", 32'(bus.if_valid), 1);
    chk("r3_if_pc", bus.if_pc, 32'h0);
    chk("r3_if_instr", bus.if_instr, 32'h1000_0000);
    chk("r3_if_pcplus4", bus.if_pcplus4, 32'h4);
    step(); chk("r4_if_pc", bus.if_pc, 32'h4); chk("r4_addr", bus.imem_req_addr, 32'h8);
    step(); chk("r5_if_valid", 32'(bus.if_valid), 0); chk("r5_addr", bus.imem_req_addr, 32'hc);
    step(); chk("r6_if_pc", bus.if_pc, 32'h8);
    step(); chk("r7_if_pc", bus.if_pc, 32'hc);

    // decode stall saturates credits
    step(); bus.dec_ready = 1'b0;
    step();
    step();
    chk("stall_req_valid", 32'(bus.imem_req_valid), 0);
    chk("stall_if_pc", bus.if_pc, 32'h10);
    chk("stall_count", 32'(dut.u_fifo.count), 2);
    chk("stall_outstanding", 32'(dut.outstanding), 0);
    step(); step();
    chk("stall_hold_pc", bus.if_pc, 32'h10);
    step(); bus.dec_ready = 1'b1; #1;
    chk("resume_if_pc0", bus.if_pc, 32'h10);
    step(); chk("resume_if_pc1", bus.if_pc, 32'h14);
    step(); step(); step(); step();
    chk("stream_log_size", pop_log.size(), 8);
    chk("stream_log_5", pop_log[5], 32'h14);
    chk("stream_log_7", pop_log[7], 32'h1c);

    // redirect with two requests in flight, latency 3
    reset = 1'b1; mem_lat = 3; pop_log.delete();
    step(); reset = 1'b0;
    step();
    step(); chk("p3_addr4", bus.imem_req_addr, 32'h4);
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #1;
    chk("p3_redir_req_valid", 32'(bus.imem_req_valid), 0);
    chk("p3_redir_if_valid", 32'(bus.if_valid), 0);
    step(); bus.redirect_valid = 1'b0; #1;
    chk("p3_drop2", 32'(dut.drop_cnt), 2);
    chk("p3_drop2_no_req", 32'(bus.imem_req_valid), 0);
    step(); chk("p3_drop1", 32'(dut.drop_cnt), 1); chk("p3_addr_tgt", bus.imem_req_addr, 32'h100);
    chk("p3_req_valid_tgt", 32'(bus.imem_req_valid), 1);
    step(); chk("p3_drop0", 32'(dut.drop_cnt), 0); chk("p3_addr_tgt4", bus.imem_req_addr, 32'h104);
    step(); step(); step();
    chk("p3_if_pc", bus.if_pc, 32'h100);
    chk("p3_if_instr", bus.if_instr, 32'h1000_0100);
    chk("p3_if_pcplus4", bus.if_pcplus4, 32'h104);

    // misaligned redirect target while an entry is queued
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203; #1;
    chk("p4_if_valid_gated", 32'(bus.if_valid), 0);
    chk("p4_req_valid_gated", 32'(bus.imem_req_valid), 0);
    step(); bus.redirect_valid = 1'b0; #1;
    chk("p4_addr", bus.imem_req_addr, 32'h200);
    step(); chk("p4_addr4", bus.imem_req_addr, 32'h204);
    step(); step(); step();
    chk("p4_if_pc", bus.if_pc, 32'h200);
    chk("p4_if_instr", bus.if_instr, 32'h1000_0200);
    step();
    chk("p4_log_size", pop_log.size(), 2);
    chk("p4_log_0", pop_log[0], 32'h100);

    // response coinciding with redirect, one outstanding, latency 1
    reset = 1'b1; mem_lat = 1; pop_log.delete();
    step(); reset = 1'b0;
    step();
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300; #1;
    chk("p5_redir_req_valid", 32'(bus.imem_req_valid), 0);
    step(); bus.redirect_valid = 1'b0; #1;
    chk("p5_drop0", 32'(dut.drop_cnt), 0);
    chk("p5_if_valid", 32'(bus.if_valid), 0);
    chk("p5_addr", bus.imem_req_addr, 32'h300);
    step(); chk("p5_addr4", bus.imem_req_addr, 32'h304);
    step();
    chk("p5_if_pc", bus.if_pc, 32'h300);
    chk("p5_if_instr", bus.if_instr, 32'h1000_0300);

    // reset with full queue and a late response landing during reset
    step(); bus.dec_ready = 1'b0;
    step();
    step(); chk("p6_full", 32'(dut.u_fifo.count), 2);
    reset = 1'b1; inj_valid = 1'b1; inj_data = 32'hdead_beef;
    step(); reset = 1'b0; inj_valid = 1'b0; bus.dec_ready = 1'b1; #1;
    chk("p6_if_valid", 32'(bus.if_valid), 0);
    chk("p6_if_pc", bus.if_pc, 32'h0);
    chk("p6_if_instr", bus.if_instr, 32'h0);
    chk("p6_pc", bus.imem_req_addr, 32'h0);
    chk("p6_boot_req", 32'(bus.imem_req_valid), 0);
    chk("p6_count", 32'(dut.u_fifo.count), 0);
    step(); chk("p6_req_valid", 32'(bus.imem_req_valid), 1); chk("p6_addr", bus.imem_req_addr, 32'h0);
    step(); step();
    chk("p6_post_if_pc", bus.if_pc, 32'h0);
    chk("p6_post_if_instr", bus.if_instr, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
